// File: rtl/axis_row_arbiter.sv
// axis_row_arbiter: shares one row-oriented AXI-Stream sink between two
// producers. Ownership is granted for a whole row of ROW_BEATS beats, chosen
// round-robin, and revoked if the owner goes quiet for IDLE_TIMEOUT cycles.
module axis_row_arbiter #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned ROW_BEATS    = 66,
  parameter int unsigned IDLE_TIMEOUT = 400000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                  S0_AXIS_TVALID,
  output logic                  S0_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                  S1_AXIS_TVALID,
  output logic                  S1_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [1:0]            grant,
  output logic                  row_complete,
  output logic                  row_abort,
  output logic [31:0]           rows_done
);

  localparam logic [15:0] LAST_BEAT = 16'(ROW_BEATS - 1);
  localparam logic [31:0] TMO_INIT  = 32'(IDLE_TIMEOUT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [1:0]  grant_d;
  logic        row_complete_d, row_abort_d;
  logic [31:0] rows_done_d;

  logic locked, sel_valid, hs;

  // Zero-latency mux: the owner's stream is wired straight through to the sink.
  always_comb begin
    locked         = (state_q == LOCKED);
    sel_valid      = owner_q ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    M_AXIS_TDATA   = (locked && owner_q) ? S1_AXIS_TDATA : S0_AXIS_TDATA;
    M_AXIS_TVALID  = locked && sel_valid;
    S0_AXIS_TREADY = locked && !owner_q && M_AXIS_TREADY;
    S1_AXIS_TREADY = locked && owner_q && M_AXIS_TREADY;
    hs             = locked && sel_valid && M_AXIS_TREADY;
  end

  // Next-state: arbitration in IDLE, beat counting and starvation watchdog in LOCKED.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    beat_cnt_d     = beat_cnt_q;
    tmo_d          = tmo_q;
    grant_d        = grant;
    row_complete_d = 1'b0;
    row_abort_d    = 1'b0;
    rows_done_d    = rows_done;
    case (state_q)
      IDLE: begin
        if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
          // S1 wins when it is alone, or when both ask and S0 owned last.
          owner_d    = S1_AXIS_TVALID && (!S0_AXIS_TVALID || !last_owner_q);
          state_d    = LOCKED;
          beat_cnt_d = '0;
          tmo_d      = TMO_INIT;
          grant_d    = owner_d ? 2'b10 : 2'b01;
        end
      end
      LOCKED: begin
        if (hs) begin
          // A beat always refreshes the watchdog, even on the same cycle it expires.
          tmo_d = TMO_INIT;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d        = IDLE;
            row_complete_d = 1'b1;
            rows_done_d    = rows_done + 32'd1;
            last_owner_d   = owner_q;
            beat_cnt_d     = '0;
            grant_d        = 2'b00;
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end else if (!sel_valid) begin
          // Only a silent owner ages; sink backpressure never evicts.
          if (tmo_q == '0) begin
            state_d      = IDLE;
            row_abort_d  = 1'b1;
            last_owner_d = owner_q;
            beat_cnt_d   = '0;
            grant_d      = 2'b00;
          end else begin
            tmo_d = tmo_q - 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered status outputs; reset drops any row in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      tmo_q        <= '0;
      grant        <= 2'b00;
      row_complete <= 1'b0;
      row_abort    <= 1'b0;
      rows_done    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      tmo_q        <= tmo_d;
      grant        <= grant_d;
      row_complete <= row_complete_d;
      row_abort    <= row_abort_d;
      rows_done    <= rows_done_d;
    end
  end

endmodule

// File: tb/tb_axis_row_arbiter.sv
// Bench for axis_row_arbiter: a vector table on a ROW_BEATS=1 instance, then
// scenario sequences on a ROW_BEATS=66 / IDLE_TIMEOUT=10 instance whose sink
// beats are checked against a queue of expected {source, index} words.
module tb_axis_row_arbiter;
  localparam int DW = 16;
  localparam int RB = 66;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- main instance ----------------
  logic          s0_on, s1_on, m_rdy, toggle_rdy;
  int            s0_idx, s1_idx, s0_lim, s1_lim;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s1_valid, s0_ready, s1_ready, m_valid;
  logic [1:0]    grant;
  logic          rc, ra;
  logic [31:0]   rows;

  assign s0_data  = {1'b0, 15'(s0_idx)};
  assign s1_data  = {1'b1, 15'(s1_idx)};
  assign s0_valid = s0_on && (s0_idx < s0_lim);
  assign s1_valid = s1_on && (s1_idx < s1_lim);

  axis_row_arbiter #(.DATA_WIDTH(DW), .ROW_BEATS(RB), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .S0_AXIS_TDATA(s0_data), .S0_AXIS_TVALID(s0_valid), .S0_AXIS_TREADY(s0_ready),
    .S1_AXIS_TDATA(s1_data), .S1_AXIS_TVALID(s1_valid), .S1_AXIS_TREADY(s1_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_rdy),
    .grant(grant), .row_complete(rc), .row_abort(ra), .rows_done(rows)
  );

  // ---------------- ROW_BEATS=1 instance for the vector table ----------------
  logic          t_s0v, t_s1v, t_mr, t_s0r, t_s1r, t_mv, t_rc, t_ra;
  logic [DW-1:0] t_s0d, t_s1d, t_md;
  logic [1:0]    t_grant;
  logic [31:0]   t_rows;
  assign t_s0d = 16'hA0A0;
  assign t_s1d = 16'hB1B1;

  axis_row_arbiter #(.DATA_WIDTH(DW), .ROW_BEATS(1), .IDLE_TIMEOUT(TO)) dut1 (
    .clk(clk), .reset(reset),
    .S0_AXIS_TDATA(t_s0d), .S0_AXIS_TVALID(t_s0v), .S0_AXIS_TREADY(t_s0r),
    .S1_AXIS_TDATA(t_s1d), .S1_AXIS_TVALID(t_s1v), .S1_AXIS_TREADY(t_s1r),
    .M_AXIS_TDATA(t_md), .M_AXIS_TVALID(t_mv), .M_AXIS_TREADY(t_mr),
    .grant(t_grant), .row_complete(t_rc), .row_abort(t_ra), .rows_done(t_rows)
  );

  typedef struct {
    logic s0v, s1v, mr;               // inputs for the cycle
    logic e_s0r, e_s1r, e_mv, e_sel1; // combinational outputs during the cycle
    logic [1:0] e_grant;              // registered outputs after the edge
    logic e_rc;
    logic [31:0] e_rows;
  } vec_t;
  vec_t tbl[10];

  // ---------------- scoreboard and per-cycle statistics ----------------
  logic [DW-1:0] exp_q[$];
  int cyc, n_g01, n_g10, n_rc, n_ra, n_s0r, last_rc_cyc, first_ra_cyc;
  logic [31:0] rows_at_ra;
  logic [1:0]  grant_after_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_row(input logic src, input int first);
    for (int i = 0; i < RB; i++) exp_q.push_back({src, 15'(first + i)});
  endtask

  // One clock: observe at the falling edge, advance producers after the rising edge.
  task automatic tick();
    logic hs0, hs1;
    logic [DW-1:0] e;
    @(negedge clk);
    if (m_valid && m_rdy) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_extra: got beat %0h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_beat", 32'(m_data), 32'(e));
      end
    end
    hs0 = s0_valid && s0_ready;
    hs1 = s1_valid && s1_ready;
    if (grant == 2'b01) n_g01++;
    if (grant == 2'b10) n_g10++;
    if (s0_ready) n_s0r++;
    if (rc) begin n_rc++; last_rc_cyc = cyc; end
    if (ra) begin
      n_ra++;
      if (first_ra_cyc < 0) begin first_ra_cyc = cyc; rows_at_ra = rows; end
    end
    if (first_ra_cyc >= 0 && cyc == first_ra_cyc + 1) grant_after_ra = grant;
    @(posedge clk); #1;
    cyc++;
    if (hs0) s0_idx++;
    if (hs1) s1_idx++;
    if (toggle_rdy) m_rdy = ~m_rdy;
  endtask

  task automatic clear_stats();
    cyc = 0; n_g01 = 0; n_g10 = 0; n_rc = 0; n_ra = 0; n_s0r = 0;
    last_rc_cyc = -1; first_ra_cyc = -1; rows_at_ra = '1; grant_after_ra = 2'b11;
  endtask

  task automatic reset_all();
    reset = 1'b1;
    s0_on = 0; s1_on = 0; m_rdy = 0; toggle_rdy = 0;
    s0_idx = 0; s1_idx = 0; s0_lim = 0; s1_lim = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    t_s0v = 0; t_s1v = 0; t_mr = 0;
    // s0v s1v mr | s0r s1r mv sel1 | grant rc rows
    tbl[0] = '{1, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0}; // both ask, S0 wins first
    tbl[1] = '{1, 1, 1, 1, 0, 1, 0, 2'b00, 1, 1}; // one beat = one row
    tbl[2] = '{1, 1, 1, 0, 0, 0, 0, 2'b10, 0, 1}; // gap cycle, round-robin to S1
    tbl[3] = '{1, 1, 0, 0, 0, 1, 1, 2'b10, 0, 1}; // sink stall holds the grant
    tbl[4] = '{1, 1, 1, 0, 1, 1, 1, 2'b00, 1, 2};
    tbl[5] = '{0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2}; // nobody asks
    tbl[6] = '{0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2}; // S1 alone wins after owning last
    tbl[7] = '{1, 0, 1, 0, 1, 0, 1, 2'b10, 0, 2}; // owner silent, S0 still blocked
    tbl[8] = '{0, 1, 1, 0, 1, 1, 1, 2'b00, 1, 3};
    tbl[9] = '{1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 3};

    reset_all();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rows", rows, 32'd0);
    chk("rst_flags", {30'd0, rc, ra}, 32'd0);
    chk("rst_ready", {29'd0, s0_ready, s1_ready, m_valid}, 32'd0);

    // Vector table on the ROW_BEATS=1 instance
    for (int i = 0; i < 10; i++) begin
      t_s0v = tbl[i].s0v; t_s1v = tbl[i].s1v; t_mr = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_s0r", i), 32'(t_s0r), 32'(tbl[i].e_s0r));
      chk($sformatf("vec%0d_s1r", i), 32'(t_s1r), 32'(tbl[i].e_s1r));
      chk($sformatf("vec%0d_mv", i), 32'(t_mv), 32'(tbl[i].e_mv));
      chk($sformatf("vec%0d_mdata", i), 32'(t_md), tbl[i].e_sel1 ? 32'hB1B1 : 32'hA0A0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_grant", i), 32'(t_grant), 32'(tbl[i].e_grant));
      chk($sformatf("vec%0d_rc", i), 32'(t_rc), 32'(tbl[i].e_rc));
      chk($sformatf("vec%0d_rows", i), t_rows, tbl[i].e_rows);
    end
    t_s0v = 0; t_s1v = 0; t_mr = 0;

    // 1: single S0 row, sink always ready
    reset_all();
    s0_lim = RB; s0_on = 1; m_rdy = 1; push_row(1'b0, 0);
    for (int k = 0; k < 300 && n_rc < 1; k++) tick();
    repeat (3) tick();
    chk("t1_grant01_cycles", 32'(n_g01), 32'(RB));
    chk("t1_rc_count", 32'(n_rc), 32'd1);
    chk("t1_rc_cycle", 32'(last_rc_cyc), 32'(RB + 1));
    chk("t1_rows", rows, 32'd1);
    chk("t1_sb_left", 32'(exp_q.size()), 32'd0);

    // 2: both producers always valid; rows alternate with one idle cycle between
    reset_all();
    s0_lim = 2 * RB; s1_lim = 2 * RB; s0_on = 1; s1_on = 1; m_rdy = 1;
    push_row(1'b0, 0); push_row(1'b1, 0); push_row(1'b0, RB); push_row(1'b1, RB);
    for (int k = 0; k < 1000 && n_rc < 4; k++) tick();
    repeat (3) tick();
    chk("t2_4th_rc_cycle", 32'(last_rc_cyc), 32'(4 * (RB + 1)));
    chk("t2_g01", 32'(n_g01), 32'(2 * RB));
    chk("t2_g10", 32'(n_g10), 32'(2 * RB));
    chk("t2_rows", rows, 32'd4);
    chk("t2_abort", 32'(n_ra), 32'd0);
    chk("t2_sb_left", 32'(exp_q.size()), 32'd0);

    // 3: S1 row under alternating sink backpressure
    reset_all();
    s1_lim = RB; s1_on = 1; m_rdy = 1; toggle_rdy = 1; push_row(1'b1, 0);
    for (int k = 0; k < 600 && n_rc < 1; k++) tick();
    toggle_rdy = 0;
    chk("t3_g10_cycles", 32'(n_g10), 32'(2 * RB));
    chk("t3_rc_cycle", 32'(last_rc_cyc), 32'(2 * RB + 1));
    chk("t3_abort", 32'(n_ra), 32'd0);
    chk("t3_s0_ready", 32'(n_s0r), 32'd0);
    chk("t3_rows", rows, 32'd1);
    chk("t3_sb_left", 32'(exp_q.size()), 32'd0);

    // 4: S0 stalls after 20 beats; last handshake edge is cycle 20's edge, the
    // watchdog counts 10..0 over the next 10 edges and aborts on the 11th,
    // so row_abort is seen in cycle 32 and S1 owns from cycle 33.
    reset_all();
    s0_lim = 20; s1_lim = RB; s0_on = 1; s1_on = 1; m_rdy = 1;
    for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, 15'(i)});
    push_row(1'b1, 0);
    for (int k = 0; k < 400 && n_rc < 1; k++) tick();
    repeat (2) tick();
    chk("t4_abort_cycle", 32'(first_ra_cyc), 32'd32);
    chk("t4_abort_count", 32'(n_ra), 32'd1);
    chk("t4_rows_at_abort", rows_at_ra, 32'd0);
    chk("t4_grant_after", 32'(grant_after_ra), 32'd2);
    chk("t4_s1_rc_cycle", 32'(last_rc_cyc), 32'd99);
    chk("t4_rows", rows, 32'd1);
    chk("t4_sb_left", 32'(exp_q.size()), 32'd0);

    // 5: reset during beat 30 of an S1 row, then S0 wins the first grant
    reset_all();
    s1_lim = 96; s1_on = 1; m_rdy = 1;
    for (int i = 0; i < 30; i++) exp_q.push_back({1'b1, 15'(i)});
    for (int k = 0; k < 100 && s1_idx < 30; k++) tick();
    chk("t5_beats_before", 32'(s1_idx), 32'd30);
    reset = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
    chk("t5_rst_mvalid", 32'(m_valid), 32'd0);
    s0_lim = RB; s0_on = 1;
    chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);
    push_row(1'b0, 0); push_row(1'b1, 30);
    @(posedge clk); #1 reset = 1'b0;
    clear_stats();
    tick();
    chk("t5_first_grant", 32'(grant), 32'd1);
    for (int k = 0; k < 400 && n_rc < 2; k++) tick();
    chk("t5_rows", rows, 32'd2);
    chk("t5_sb_left", 32'(exp_q.size()), 32'd0);

    // 6: rows_done wraps from all-ones to zero
    reset_all();
    force dut.rows_done = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.rows_done;
    @(posedge clk); #1;
    chk("t6_preset", rows, 32'hFFFF_FFFF);
    s0_lim = RB; s0_on = 1; m_rdy = 1; push_row(1'b0, 0);
    for (int k = 0; k < 300 && n_rc < 1; k++) tick();
    tick();
    chk("t6_rc_count", 32'(n_rc), 32'd1);
    chk("t6_wrap", rows, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
